fp_add_subt_unit: RTL and testbench

FP_ADD_SUBT_UNIT -- requirements
Module: fp_add_subt_unit

---
 rtl/fp_add_subt_unit.sv | 200 ++++++++++++++++++++
 tb/tb_fp_add_subt_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_subt_unit.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor, round-to-nearest-even, denormals flushed.
// Define FPADD_SPECIAL_EN to handle infinity/NaN operands; otherwise exponent 255 is treated as finite.
module fp_add_subt_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        beg_add_subt,
    input  logic        ack_add_subt,
    input  logic        add_subt,
    input  logic [31:0] Data_X,
    input  logic [31:0] Data_Y,
    output logic        ready_add_subt,
    output logic [31:0] result,
    output logic        overflow_flag,
    output logic        underflow_flag
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] x_q, y_q;
    logic        op_q;
    logic        sign_q;
    logic        eff_sub_q;
    logic [9:0]  exp_q;
    logic [26:0] big_q, small_q;
    logic [27:0] sum_q;
    logic        zero_q;
    logic        uf_q;

    // Operand ordering and alignment, evaluated from the captured operands.
    logic [7:0]  exp_x, exp_y, exp_big, exp_diff;
    logic [23:0] sig_x, sig_y, sig_big, sig_small;
    logic [53:0] shift_wide;
    logic [26:0] small_aligned;
    logic        x_big, sign_y_eff, sign_big, eff_sub;

    always_comb begin
        exp_x      = x_q[30:23];
        exp_y      = y_q[30:23];
        sig_x      = (exp_x != 8'd0) ? {1'b1, x_q[22:0]} : 24'd0;
        sig_y      = (exp_y != 8'd0) ? {1'b1, y_q[22:0]} : 24'd0;
        x_big      = {exp_x, sig_x[22:0]} >= {exp_y, sig_y[22:0]};
        sign_y_eff = y_q[31] ^ op_q;
        eff_sub    = op_q ^ x_q[31] ^ y_q[31];
        sign_big   = x_big ? x_q[31] : sign_y_eff;
        exp_big    = x_big ? exp_x : exp_y;
        exp_diff   = x_big ? (exp_x - exp_y) : (exp_y - exp_x);
        sig_big    = x_big ? sig_x : sig_y;
        sig_small  = x_big ? sig_y : sig_x;
        // Upper 27 bits are the aligned field, the low 27 catch everything shifted past sticky.
        shift_wide = {sig_small, 30'd0} >> exp_diff;
        if (exp_diff >= 8'd27) begin
            small_aligned = {26'd0, |sig_small};
        end else begin
            small_aligned = {shift_wide[53:28], shift_wide[27] | (|shift_wide[26:0])};
        end
    end

`ifdef FPADD_SPECIAL_EN
    logic        x_inf, y_inf, x_nan, y_nan, special_hit;
    logic [31:0] special_res;

    always_comb begin
        x_inf       = (exp_x == 8'hFF) && (x_q[22:0] == 23'd0);
        y_inf       = (exp_y == 8'hFF) && (y_q[22:0] == 23'd0);
        x_nan       = (exp_x == 8'hFF) && (x_q[22:0] != 23'd0);
        y_nan       = (exp_y == 8'hFF) && (y_q[22:0] != 23'd0);
        special_hit = (exp_x == 8'hFF) || (exp_y == 8'hFF);
        if (x_nan || y_nan || (x_inf && y_inf && eff_sub)) begin
            special_res = 32'h7FC0_0000;
        end else if (x_inf) begin
            special_res = x_q;
        end else begin
            special_res = {sign_y_eff, 8'hFF, 23'd0};
        end
    end
`endif

    // Rounding on guard/round/sticky; a carry out renormalises by one.
    logic        round_up;
    logic [24:0] mant_sum;
    logic [9:0]  exp_rnd;
    logic [22:0] mant_rnd;

    always_comb begin
        round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        mant_sum = {1'b0, sum_q[26:3]} + {24'd0, round_up};
        exp_rnd  = exp_q + {9'd0, mant_sum[24]};
        mant_rnd = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            x_q            <= 32'd0;
            y_q            <= 32'd0;
            op_q           <= 1'b0;
            sign_q         <= 1'b0;
            eff_sub_q      <= 1'b0;
            exp_q          <= 10'd0;
            big_q          <= 27'd0;
            small_q        <= 27'd0;
            sum_q          <= 28'd0;
            zero_q         <= 1'b0;
            uf_q           <= 1'b0;
            ready_add_subt <= 1'b0;
            result         <= 32'd0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (beg_add_subt) state_q <= StLoad;
                end
                StLoad: begin
                    x_q            <= Data_X;
                    y_q            <= Data_Y;
                    op_q           <= add_subt;
                    overflow_flag  <= 1'b0;
                    underflow_flag <= 1'b0;
                    state_q        <= StAlign;
                end
                StAlign: begin
`ifdef FPADD_SPECIAL_EN
                    if (special_hit) begin
                        result         <= special_res;
                        ready_add_subt <= 1'b1;
                        state_q        <= StDone;
                    end else
`endif
                    begin
                        exp_q     <= {2'b00, exp_big};
                        big_q     <= {sig_big, 3'b000};
                        small_q   <= small_aligned;
                        sign_q    <= sign_big;
                        eff_sub_q <= eff_sub;
                        state_q   <= StAdd;
                    end
                end
                StAdd: begin
                    sum_q   <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                         : ({1'b0, big_q} + {1'b0, small_q});
                    zero_q  <= 1'b0;
                    uf_q    <= 1'b0;
                    state_q <= StNorm;
                end
                StNorm: begin
                    if (sum_q == 28'd0) begin
                        zero_q  <= 1'b1;
                        state_q <= StRound;
                    end else if (sum_q[27]) begin
                        sum_q   <= {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
                        exp_q   <= exp_q + 10'd1;
                        state_q <= StRound;
                    end else if (sum_q[26]) begin
                        state_q <= StRound;
                    end else if (exp_q == 10'd1) begin
                        // One more left shift would take the exponent to zero.
                        uf_q    <= 1'b1;
                        state_q <= StRound;
                    end else begin
                        sum_q <= {sum_q[26:0], 1'b0};
                        exp_q <= exp_q - 10'd1;
                    end
                end
                StRound: begin
                    if (zero_q) begin
                        result <= 32'd0;
                    end else if (uf_q) begin
                        result         <= {sign_q, 31'd0};
                        underflow_flag <= 1'b1;
                    end else if (exp_rnd >= 10'd255) begin
                        result        <= {sign_q, 8'hFF, 23'd0};
                        overflow_flag <= 1'b1;
                    end else begin
                        result <= {sign_q, exp_rnd[7:0], mant_rnd};
                    end
                    ready_add_subt <= 1'b1;
                    state_q        <= StDone;
                end
                StDone: begin
                    if (ack_add_subt) begin
                        ready_add_subt <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_subt_unit.sv
// Self-checking bench for fp_add_subt_unit: exact-arithmetic reference model plus literal vectors.
module tb_fp_add_subt_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        beg_add_subt;
    logic        ack_add_subt;
    logic        add_subt;
    logic [31:0] Data_X;
    logic [31:0] Data_Y;
    logic        ready_add_subt;
    logic [31:0] result;
    logic        overflow_flag;
    logic        underflow_flag;

    fp_add_subt_unit dut (
        .clk            (clk),
        .reset          (reset),
        .beg_add_subt   (beg_add_subt),
        .ack_add_subt   (ack_add_subt),
        .add_subt       (add_subt),
        .Data_X         (Data_X),
        .Data_Y         (Data_Y),
        .ready_add_subt (ready_add_subt),
        .result         (result),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: exact signed sum of the two values on a common binary scale, then RNE.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic op,
                         output logic [31:0] r, output logic o, output logic u, output int lat);
        int ex, ey, lo, eb, p, e, sh;
        logic [23:0]  mx, my;
        logic [299:0] a, b, mag, rem, half;
        logic         sa, sb, sr, up;
        logic [24:0]  m;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sa = x[31];
        sb = y[31] ^ op;
        o = 1'b0;
        u = 1'b0;
        lat = 5;
`ifdef FPADD_SPECIAL_EN
        if (ex == 255 || ey == 255) begin
            lat = 2;
            if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
                (ex == 255 && ey == 255 && sa != sb))
                r = 32'h7FC0_0000;
            else if (ex == 255)
                r = x;
            else
                r = {sb, 8'hFF, 23'd0};
            return;
        end
`endif
        mx = (ex != 0) ? {1'b1, x[22:0]} : 24'd0;
        my = (ey != 0) ? {1'b1, y[22:0]} : 24'd0;
        lo = (ex < ey) ? ex : ey;
        eb = (ex > ey) ? ex : ey;
        a = 300'(mx) << (ex - lo);
        b = 300'(my) << (ey - lo);
        if (sa == sb) begin
            mag = a + b; sr = sa;
        end else if (a >= b) begin
            mag = a - b; sr = sa;
        end else begin
            mag = b - a; sr = sb;
        end
        if (mag == 0) begin
            r = 32'd0;
            return;
        end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = lo + p - 23;
        if (e <= 0) begin
            r = {sr, 31'd0};
            u = 1'b1;
            lat = 5 + eb - 1;
            return;
        end
        if (e < eb) lat = 5 + eb - e;
        if (p > 23) begin
            sh = p - 23;
            m = 25'(mag >> sh);
            rem = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            up = (rem > half) || (rem == half && m[0]);
            m = m + 25'(up);
        end else begin
            m = 25'(mag << (23 - p));
        end
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) begin
            r = {sr, 8'hFF, 23'd0};
            o = 1'b1;
        end else begin
            r = {sr, e[7:0], m[22:0]};
        end
    endtask

    typedef struct {
        logic [31:0] x, y;
        logic        op;
        logic [31:0] res;
        logic [1:0]  flags;
        int          lat;
        int          ack_dly;
        bit          lit;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] x, input logic [31:0] y, input logic op,
                           input logic [31:0] res, input logic [1:0] flags, input int lat,
                           input int ack_dly, input bit lit);
        vec_t v;
        v.x = x; v.y = y; v.op = op; v.res = res; v.flags = flags;
        v.lat = lat; v.ack_dly = ack_dly; v.lit = lit;
        vecs.push_back(v);
    endtask

    // Compare process: whenever a result is presented, it must match the model.
    logic        chk_en = 1'b0;
    logic [31:0] exp_res;
    logic        exp_ovf, exp_unf;

    always @(negedge clk) begin
        if (chk_en && ready_add_subt) begin
            check("model_result", result, exp_res);
            check("model_flags", {30'd0, overflow_flag, underflow_flag}, {30'd0, exp_ovf, exp_unf});
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] mres;
        logic        mo, mu;
        int          mlat, cnt;
        bit          got;
        model(v.x, v.y, v.op, mres, mo, mu, mlat);
        if (v.lit) begin
            check("model_pin_res", mres, v.res);
            check("model_pin_lat", mlat, v.lat);
        end
        exp_res = mres; exp_ovf = mo; exp_unf = mu;
        @(posedge clk); #1;
        Data_X = v.x; Data_Y = v.y; add_subt = v.op; beg_add_subt = 1'b1;
        @(posedge clk); #1 beg_add_subt = 1'b0;
        chk_en = 1'b1;
        cnt = 0;
        got = 0;
        while (cnt < 200 && !got) begin
            @(posedge clk); #1 cnt++;
            if (cnt == 1) begin
                Data_X = $urandom; Data_Y = $urandom; add_subt = ~add_subt;
            end
            if (ready_add_subt) got = 1;
        end
        if (!got) begin
            check("ready_timeout", 32'(cnt), 32'(mlat));
            chk_en = 1'b0;
            pulse_reset();
            return;
        end
        check("latency", cnt, mlat);
        if (v.lit) begin
            check("lit_result", result, v.res);
            check("lit_flags", {30'd0, overflow_flag, underflow_flag}, {30'd0, v.flags});
            check("lit_latency", cnt, v.lat);
        end
        for (int i = 0; i < v.ack_dly; i++) begin
            @(posedge clk); #1 check("ready_hold", {31'd0, ready_add_subt}, 32'd1);
        end
        ack_add_subt = 1'b1;
        @(posedge clk); #1 ack_add_subt = 1'b0;
        chk_en = 1'b0;
        check("ready_drop", {31'd0, ready_add_subt}, 32'd0);
        @(posedge clk); #1 check("idle_keep", result, mres);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; beg_add_subt = 1'b1; ack_add_subt = 1'b1;
        add_subt = 1'b0; Data_X = 32'd0; Data_Y = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_add_subt}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
        beg_add_subt = 1'b0; ack_add_subt = 1'b0;
        reset = 1'b1;

        //       X             Y             op    result        {ovf,unf} lat dly lit
        add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00, 5,  0,  1);
        add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00, 5,  10, 1);
        add_vec(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 2'b00, 29, 1,  1);
        add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00, 5,  0,  1);
        add_vec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 2'b00, 5,  2,  1);
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b10, 5,  1,  1);
        add_vec(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 2'b01, 5,  0,  1);
        add_vec(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 2'b00, 5,  0,  1);
        add_vec(32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 2'b00, 5,  0,  1);
        add_vec(32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 2'b00, 5,  0,  1);
        add_vec(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF, 2'b00, 5,  0,  1);
        add_vec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 2'b00, 5,  0,  1);
`ifdef FPADD_SPECIAL_EN
        add_vec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b00, 2,  1,  1);
        add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2'b00, 2,  0,  1);
`else
        add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2'b10, 5,  0,  1);
`endif
        for (int i = 0; i < 12; i++) begin
            logic [31:0] rx, ry;
            rx = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            ry = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            add_vec(rx, ry, 1'($urandom), 32'd0, 2'b00, 0, i % 3, 0);
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a long normalisation, then a clean transaction.
        @(posedge clk); #1;
        Data_X = 32'h3F800000; Data_Y = 32'h3F7FFFFF; add_subt = 1'b1; beg_add_subt = 1'b1;
        @(posedge clk); #1 beg_add_subt = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        check("midrst_ready", {31'd0, ready_add_subt}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
        repeat (30) @(posedge clk);
        #1 check("midrst_no_ready", {31'd0, ready_add_subt}, 32'd0);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
